// File: rtl/pwm_cfg_sequencer_if.sv
// Pin-side bundle of the PWM configuration sequencer: panel buttons, REF switches,
// mode/enable, and the configuration handed to the PWM core.
interface pwm_cfg_sequencer_if;
  logic       MEn;
  logic       Modo_i;
  logic       aumC_i;
  logic       bajaC_i;
  logic       aumf_i;
  logic       bajaf_i;
  logic [3:0] REF;
  logic [7:0] numF_o;
  logic [3:0] duty_o;
  logic       cfg_ld_o;
  logic       busy_o;

  modport master (
    output MEn, Modo_i, aumC_i, bajaC_i, aumf_i, bajaf_i, REF,
    input  numF_o, duty_o, cfg_ld_o, busy_o
  );

  modport slave (
    input  MEn, Modo_i, aumC_i, bajaC_i, aumf_i, bajaf_i, REF,
    output numF_o, duty_o, cfg_ld_o, busy_o
  );
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// Button debounce, request arbitration and saturating duty/frequency registers for the PWM core.
// Optional auto-repeat on held buttons: define PWM_CFG_AUTOREPEAT_EN.
module pwm_cfg_sequencer #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned REP_CYCLES = 64,
  parameter int unsigned F_MIN      = 1,
  parameter int unsigned F_MAX      = 200,
  parameter int unsigned F_INIT     = 50,
  parameter int unsigned D_MAX      = 10,
  parameter int unsigned D_INIT     = 5
) (
  input logic             CLKNEXYS,
  input logic             MRst,
  pwm_cfg_sequencer_if.slave bus
);

  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StUpd, StLoad} state_e;

  // Button order: 0 duty up, 1 duty down, 2 freq up, 3 freq down.
  logic [3:0]      raw;
  logic [3:0]      sync1_q, sync2_q, stable_q, press, evt;
  logic [DebW-1:0] deb_cnt_q [4];
  logic [3:0]      ref_q;
  logic            modo_q;
  logic            ref_evt;
  // Pending flags: 0 duty_up, 1 duty_dn, 2 f_up, 3 f_dn, 4 ref_upd.
  logic [4:0]      pend_q, pend_d, new_req, pend_all, req;
  logic [7:0]      numf_q, numf_d;
  logic [3:0]      duty_q, duty_d;
  state_e          state_q, state_d;

  assign raw = {bus.bajaf_i, bus.aumf_i, bus.bajaC_i, bus.aumC_i};

  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++) begin
      press[i] = sync2_q[i] & ~stable_q[i] & (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1));
    end
  end

  always_ff @(posedge CLKNEXYS or posedge MRst) begin
    if (MRst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          deb_cnt_q[i] <= '0;
          stable_q[i]  <= sync2_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef PWM_CFG_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REP_CYCLES + 1);

  logic [RepW-1:0] rep_cnt_q [4];
  logic [3:0]      rep_evt;

  always_comb begin
    rep_evt = '0;
    for (int i = 0; i < 4; i++) begin
      rep_evt[i] = stable_q[i] & (rep_cnt_q[i] == RepW'(REP_CYCLES - 1));
    end
  end

  // Hold time counts from the press; each wrap is one repeat event.
  always_ff @(posedge CLKNEXYS or posedge MRst) begin
    if (MRst) begin
      for (int i = 0; i < 4; i++) rep_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!stable_q[i] || rep_evt[i]) rep_cnt_q[i] <= '0;
        else                            rep_cnt_q[i] <= rep_cnt_q[i] + 1'b1;
      end
    end
  end

  assign evt = press | rep_evt;
`else
  assign evt = press;
`endif

  // Mode entry counts as a REF change so duty snaps to REF immediately.
  assign ref_evt = bus.Modo_i & ((bus.REF != ref_q) | ~modo_q);

  always_comb begin
    new_req     = {ref_evt, evt[3], evt[2], evt[1] & ~bus.Modo_i, evt[0] & ~bus.Modo_i};
    new_req     = bus.MEn ? new_req : 5'b0;
    pend_all    = pend_q | new_req;
    pend_all[1:0] = bus.Modo_i ? 2'b00 : pend_all[1:0];
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_all;
    duty_d  = duty_q;
    numf_d  = numf_q;
    req     = pend_all;
    unique case (state_q)
      StIdle: begin
        if (bus.MEn && (|pend_all)) state_d = StUpd;
      end
      StUpd: begin
        state_d = StIdle;
        if (req[0] && req[1]) req[1:0] = 2'b00;
        if (req[2] && req[3]) req[3:2] = 2'b00;
        pend_d = req;
        if (req[4]) begin
          pend_d[4] = 1'b0;
          duty_d    = (32'(ref_q) > D_MAX) ? 4'(D_MAX) : ref_q;
        end else if (req[0]) begin
          pend_d[0] = 1'b0;
          duty_d    = (32'(duty_q) >= D_MAX) ? duty_q : duty_q + 4'd1;
        end else if (req[1]) begin
          pend_d[1] = 1'b0;
          duty_d    = (duty_q == 4'd0) ? duty_q : duty_q - 4'd1;
        end else if (req[2]) begin
          pend_d[2] = 1'b0;
          numf_d    = (32'(numf_q) >= F_MAX) ? numf_q : numf_q + 8'd1;
        end else if (req[3]) begin
          pend_d[3] = 1'b0;
          numf_d    = (32'(numf_q) <= F_MIN) ? numf_q : numf_q - 8'd1;
        end
        if ((duty_d != duty_q) || (numf_d != numf_q)) state_d = StLoad;
      end
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Disabling finishes the current pass but drops everything still queued.
    if (!bus.MEn) pend_d = '0;
  end

  always_ff @(posedge CLKNEXYS or posedge MRst) begin
    if (MRst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      numf_q  <= 8'(F_INIT);
      duty_q  <= 4'(D_INIT);
      ref_q   <= '0;
      modo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      numf_q  <= numf_d;
      duty_q  <= duty_d;
      ref_q   <= bus.REF;
      modo_q  <= bus.Modo_i;
    end
  end

  assign bus.numF_o   = numf_q;
  assign bus.duty_o   = duty_q;
  assign bus.cfg_ld_o = (state_q == StLoad);
  assign bus.busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer: debounce, saturation, cancellation, auto mode, enable.
module tb_pwm_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         ld_cnt   = 0;
  int         ld_base;

  pwm_cfg_sequencer_if bus ();

  pwm_cfg_sequencer dut (
    .CLKNEXYS (clk),
    .MRst     (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  assign bus.aumC_i  = btn[0];
  assign bus.bajaC_i = btn[1];
  assign bus.aumf_i  = btn[2];
  assign bus.bajaf_i = btn[3];

  always @(negedge clk) if (bus.cfg_ld_o === 1'b1) ld_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a button pattern, release, then leave time for debounce and update.
  task automatic hold_btn(input logic [3:0] pat, input int cycles);
    btn = pat;
    idle(cycles);
    btn = 4'b0;
    idle(40);
  endtask

  task automatic mark();
    @(negedge clk);
    ld_base = ld_cnt;
    idle(1);
  endtask

  initial begin
    rst        = 1'b1;
    btn        = 4'b0;
    bus.MEn    = 1'b1;
    bus.Modo_i = 1'b0;
    bus.REF    = 4'd0;
    idle(4);
    @(negedge clk);
    check("rst_numF", 32'(bus.numF_o), 50);
    check("rst_duty", 32'(bus.duty_o), 5);
    check("rst_ld",   32'(bus.cfg_ld_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    mark();
    rst = 1'b0;
    idle(30);
    check("rel_no_ld", 32'(ld_cnt - ld_base), 0);

    // Single frequency press
    mark();
    hold_btn(4'b0100, 20);
    check("fup_numF", 32'(bus.numF_o), 51);
    check("fup_ld",   32'(ld_cnt - ld_base), 1);
    check("fup_duty", 32'(bus.duty_o), 5);

    // Bounce shorter than the debounce window
    mark();
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      idle(3);
    end
    btn = 4'b0;
    idle(40);
    check("bounce_duty", 32'(bus.duty_o), 5);
    check("bounce_ld",   32'(ld_cnt - ld_base), 0);

    // Duty saturation at D_MAX
    mark();
    for (int i = 0; i < 5; i++) hold_btn(4'b0001, 20);
    check("sat_duty5", 32'(bus.duty_o), 10);
    check("sat_ld5",   32'(ld_cnt - ld_base), 5);
    mark();
    hold_btn(4'b0001, 20);
    check("sat_duty6", 32'(bus.duty_o), 10);
    check("sat_ld6",   32'(ld_cnt - ld_base), 0);

    // Two decrements, then simultaneous up/down cancel
    hold_btn(4'b0010, 20);
    hold_btn(4'b0010, 20);
    check("dn_duty", 32'(bus.duty_o), 8);
    mark();
    hold_btn(4'b0011, 20);
    check("cancel_duty", 32'(bus.duty_o), 8);
    check("cancel_ld",   32'(ld_cnt - ld_base), 0);
    mark();
    hold_btn(4'b0111, 20);
    check("cancel_f_duty", 32'(bus.duty_o), 8);
    check("cancel_f_numF", 32'(bus.numF_o), 52);
    check("cancel_f_ld",   32'(ld_cnt - ld_base), 1);

    // Auto mode
    mark();
    bus.Modo_i = 1'b1;
    bus.REF    = 4'd2;
    idle(10);
    check("auto_duty2", 32'(bus.duty_o), 2);
    check("auto_ld2",   32'(ld_cnt - ld_base), 1);
    mark();
    bus.REF = 4'd12;
    idle(10);
    check("auto_duty12", 32'(bus.duty_o), 10);
    check("auto_ld12",   32'(ld_cnt - ld_base), 1);
    mark();
    hold_btn(4'b0010, 20);
    hold_btn(4'b0001, 20);
    check("auto_btn_duty", 32'(bus.duty_o), 10);
    check("auto_btn_ld",   32'(ld_cnt - ld_base), 0);
    bus.Modo_i = 1'b0;
    idle(5);

    // Disabled: events discarded
    mark();
    bus.MEn = 1'b0;
    hold_btn(4'b1000, 20);
    bus.MEn = 1'b1;
    idle(10);
    check("men0_numF", 32'(bus.numF_o), 52);
    check("men0_ld",   32'(ld_cnt - ld_base), 0);

    // Long hold of frequency down
    mark();
    hold_btn(4'b1000, 16 + 3 * 64);
`ifdef PWM_CFG_AUTOREPEAT_EN
    check("hold_numF", 32'(bus.numF_o), 48);
    check("hold_ld",   32'(ld_cnt - ld_base), 4);
`else
    check("hold_numF", 32'(bus.numF_o), 51);
    check("hold_ld",   32'(ld_cnt - ld_base), 1);
`endif

    // Reset in the middle of a pending update
    btn = 4'b0001;
    idle(19);
    rst = 1'b1;
    idle(2);
    btn = 4'b0;
    check("rst2_duty", 32'(bus.duty_o), 5);
    check("rst2_numF", 32'(bus.numF_o), 50);
    mark();
    rst = 1'b0;
    idle(40);
    check("rst2_ld", 32'(ld_cnt - ld_base), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
